load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the instruction decoder in the RV32I core.
- Consumes the decoder's mem_wr_req, load_size and load_unsigned controls, plus the adder-computed effective address and the rs2 store data.
- Runs one data-memory transaction at a time over a req/ack bus and returns a sign- or zero-extended load result for the write-back mux.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_align_ext.sv | 31 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: access sizes, FSM states,
// data width and the alignment rule used by the access check.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_BUS,
    S_DONE
  } lsu_state_e;

  // Size 2'b11 is treated as a word access.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic mis;
    mis = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: mis = 1'b0;
      size == SZ_HALF: mis = off[0];
      default:         mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load lane select plus sign/zero extension of the bus read word.
// Ports: rdata_i word, off_i byte offset, size_i, uns_i -> data_o.
module load_align_ext
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        bs;
  logic        hs;

  always_comb begin
    b  = rdata_i[{off_i, 3'b000} +: 8];
    h  = rdata_i[{off_i[1], 4'b0000} +: 16];
    bs = ~uns_i & b[7];
    hs = ~uns_i & h[15];
    data_o = rdata_i;
    unique case (1'b1)
      size_i == SZ_BYTE: data_o = {{(XLEN-8){bs}}, b};
      size_i == SZ_HALF: data_o = {{(XLEN-16){hs}}, h};
      default:           data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction at a time.
// Ports: decoder controls + addr/rs2 in, dmem bus, load result, status.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            req_valid_in,
  input  logic            mem_rd_req_in,
  input  logic            mem_wr_req_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] store_data_in,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_ack_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  output logic [XLEN-1:0] load_data_o,
  output logic            done_o,
  output logic            stall_o,
  output logic            misaligned_o,
  output logic            bus_err_o
);

  import lsu_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] ld_ext;

  assign accept = (state_q == S_IDLE) & req_valid_in
                & (mem_rd_req_in | mem_wr_req_in);

  // Gated by reset so every output reads 0 while rst_in is low.
  assign stall_o = rst_in & (accept
                 | (state_q == S_CHECK)
                 | (state_q == S_BUS));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = sdata_q;
    unique case (1'b1)
      size_q == SZ_BYTE: begin
        be_d    = 4'b0001 << addr_q[1:0];
        wdata_d = {4{sdata_q[7:0]}};
      end
      size_q == SZ_HALF: begin
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
    if (!we_q) be_d = 4'b0000;
  end

  load_align_ext u_ext (
    .rdata_i (dmem_rdata_in),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (ld_ext)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      sdata_q      <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= 4'b0000;
      load_data_o  <= '0;
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= addr_in;
            sdata_q <= store_data_in;
            size_q  <= load_size_in;
            uns_q   <= load_unsigned_in;
            // Store wins when both directions are flagged.
            we_q    <= mem_wr_req_in;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (is_misaligned(size_q, addr_q[1:0])) begin
            state_q      <= S_DONE;
            done_o       <= 1'b1;
            misaligned_o <= 1'b1;
          end else begin
            state_q      <= S_BUS;
            cnt_q        <= '0;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= we_q;
            dmem_addr_o  <= {addr_q[XLEN-1:2], 2'b00};
            dmem_wdata_o <= wdata_d;
            dmem_be_o    <= be_d;
          end
        end
        S_BUS: begin
          if (dmem_ack_in || cnt_q == CNT_LAST) begin
            if (dmem_ack_in && !we_q) load_data_o <= ld_ext;
            bus_err_o    <= ~dmem_ack_in;
            done_o       <= 1'b1;
            state_q      <= S_DONE;
            cnt_q        <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_be_o    <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table,
// reset-in-flight sequence and randomized reference-model run.
module tb_load_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        mem_rd_req_in = 1'b0;
  logic        mem_wr_req_in = 1'b0;
  logic [1:0]  load_size_in = 2'b00;
  logic        load_unsigned_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data_in = '0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic [31:0] load_data_o;
  logic        done_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        bus_err_o;

  load_store_unit #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .mem_rd_req_in    (mem_rd_req_in),
    .mem_wr_req_in    (mem_wr_req_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .addr_in          (addr_in),
    .store_data_in    (store_data_in),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_ack_in      (dmem_ack_in),
    .dmem_rdata_in    (dmem_rdata_in),
    .load_data_o      (load_data_o),
    .done_o           (done_o),
    .stall_o          (stall_o),
    .misaligned_o     (misaligned_o),
    .bus_err_o        (bus_err_o)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          done_cyc;
    int          req_cyc;
    bit          mis;
    bit          berr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wa;
    logic        we;
    logic [31:0] ld;
    bit          stall_bad;
    bit          unstable;
    bit          pulse_bad;
  } res_t;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdv;
    int          dly;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
    bit          mis;
    bit          berr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wr, rd, input logic [1:0] sz,
                     input logic un, input logic [31:0] a, sd, rdv,
                     input int dly, input logic [3:0] be,
                     input logic [31:0] wd, ld, input bit mis, berr);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sz = sz; v.un = un; v.a = a;
    v.sd = sd; v.rdv = rdv; v.dly = dly; v.be = be; v.wd = wd;
    v.ld = ld; v.mis = mis; v.berr = berr;
    tbl.push_back(v);
  endtask

  // dly = BUS cycles before ack (0 = first); >= 16 means no ack.
  task automatic run_txn(input logic wr, rd, input logic [1:0] sz,
                         input logic un, input logic [31:0] a, sd, rdv,
                         input int dly, output res_t r);
    int k;
    r.done_cyc = -1; r.req_cyc = 0; r.mis = 0; r.berr = 0;
    r.be = '0; r.wd = '0; r.wa = '0; r.we = 0; r.ld = '0;
    r.stall_bad = 0; r.unstable = 0; r.pulse_bad = 0;
    k = 0;
    @(negedge clk_in);
    req_valid_in = 1; mem_wr_req_in = wr; mem_rd_req_in = rd;
    load_size_in = sz; load_unsigned_in = un;
    addr_in = a; store_data_in = sd;
    #1;
    if (stall_o !== 1'b1) r.stall_bad = 1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk_in);
      // Garbage on the request inputs must be ignored while busy.
      mem_wr_req_in = 1'($urandom); mem_rd_req_in = 1'($urandom);
      load_size_in = 2'($urandom); load_unsigned_in = 1'($urandom);
      addr_in = $urandom; store_data_in = $urandom;
      dmem_ack_in = 0; dmem_rdata_in = $urandom;
      if (done_o) begin
        r.done_cyc = c; r.mis = misaligned_o;
        r.berr = bus_err_o; r.ld = load_data_o;
        if (stall_o !== 1'b0) r.stall_bad = 1;
        break;
      end
      if (stall_o !== 1'b1) r.stall_bad = 1;
      if (dmem_req_o) begin
        if (k == 0) begin
          r.be = dmem_be_o; r.wd = dmem_wdata_o;
          r.wa = dmem_addr_o; r.we = dmem_we_o;
        end else if (r.be !== dmem_be_o || r.wd !== dmem_wdata_o ||
                     r.wa !== dmem_addr_o || r.we !== dmem_we_o) begin
          r.unstable = 1;
        end
        if (k == dly) begin
          dmem_ack_in = 1; dmem_rdata_in = rdv;
        end
        k++;
      end
    end
    r.req_cyc = k;
    req_valid_in = 0; dmem_ack_in = 0;
    @(negedge clk_in);
    if (done_o !== 1'b0 || stall_o !== 1'b0) r.pulse_bad = 1;
  endtask

  task automatic compare(input string t, input res_t r,
                         input logic wr, input logic [31:0] a,
                         input int dly, input bit mis, berr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] ld);
    int ed;
    int er;
    ed = mis ? 2 : (berr ? 18 : 3 + dly);
    er = mis ? 0 : (berr ? 16 : dly + 1);
    chk($sformatf("%s.done_cyc", t), r.done_cyc, ed);
    chk($sformatf("%s.req_cyc", t), r.req_cyc, er);
    chk($sformatf("%s.mis", t), 32'(r.mis), 32'(mis));
    chk($sformatf("%s.berr", t), 32'(r.berr), 32'(berr));
    if (er > 0) begin
      chk($sformatf("%s.addr", t), r.wa, {a[31:2], 2'b00});
      chk($sformatf("%s.we", t), 32'(r.we), 32'(wr));
      chk($sformatf("%s.be", t), 32'(r.be), 32'(be));
      if (wr) chk($sformatf("%s.wdata", t), r.wd, wd);
    end
    chk($sformatf("%s.load", t), r.ld, ld);
    chk($sformatf("%s.stall", t), 32'(r.stall_bad), 0);
    chk($sformatf("%s.stable", t), 32'(r.unstable), 0);
    chk($sformatf("%s.pulse", t), 32'(r.pulse_bad), 0);
  endtask

  // Reference model from the access rules, byte by byte.
  task automatic model(input logic wr, input logic [1:0] sz,
                       input logic un, input logic [31:0] a, sd, rdv,
                       input logic [31:0] ld_prev, input bit tmo,
                       output logic [3:0] be, output logic [31:0] wd,
                       output logic [31:0] ld, output bit mis);
    int n;
    int off;
    longint v;
    n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    off = int'(a[1:0]);
    mis = (off % n) != 0;
    be = '0; wd = '0; ld = ld_prev;
    for (int i = 0; i < 4; i++) begin
      if (wr && i >= off && i < off + n) be[i] = 1'b1;
      wd[8*i +: 8] = sd[8*(i % n) +: 8];
    end
    if (!wr && !mis && !tmo) begin
      v = longint'(rdv >> (8 * off)) & ((64'sd1 <<< (8 * n)) - 1);
      if (!un && n < 4 && v >= (64'sd1 <<< (8 * n - 1)))
        v = v - (64'sd1 <<< (8 * n));
      ld = v[31:0];
    end
  endtask

  initial begin
    res_t r;
    vec_t v;
    logic [31:0] ld_m;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic [31:0] mld;
    bit          mmis;

    req_valid_in = 1; mem_rd_req_in = 1;
    repeat (3) @(negedge clk_in);
    chk("rst.req", 32'(dmem_req_o), 0);
    chk("rst.stall", 32'(stall_o), 0);
    chk("rst.load", load_data_o, 0);
    chk("rst.others", 32'(|{dmem_we_o, dmem_addr_o, dmem_wdata_o,
        dmem_be_o, done_o, misaligned_o, bus_err_o}), 0);
    req_valid_in = 0; mem_rd_req_in = 0;
    rst_in = 1;
    @(negedge clk_in);

    add(1,0,2'b00,0,32'h1002,32'h000000AB,32'h0,0,
        4'b0100,32'hABABABAB,32'h0,0,0);
    add(0,1,2'b00,0,32'h2003,32'h0,32'h80FFFFFF,0,
        4'b0000,32'h0,32'hFFFFFF80,0,0);
    add(0,1,2'b00,1,32'h2003,32'h0,32'h80FFFFFF,1,
        4'b0000,32'h0,32'h00000080,0,0);
    add(0,1,2'b01,0,32'h2001,32'h0,32'h0,0,
        4'b0000,32'h0,32'h00000080,1,0);
    add(0,1,2'b10,0,32'h2000,32'h0,32'h12345678,5,
        4'b0000,32'h0,32'h12345678,0,0);
    add(0,1,2'b10,0,32'h2004,32'h0,32'h0,99,
        4'b0000,32'h0,32'h12345678,0,1);
    add(1,0,2'b01,0,32'h3002,32'h0000BEEF,32'h0,2,
        4'b1100,32'hBEEFBEEF,32'h12345678,0,0);
    add(0,1,2'b01,1,32'h4002,32'h0,32'h80017FFF,0,
        4'b0000,32'h0,32'h00008001,0,0);
    add(0,1,2'b01,0,32'h4002,32'h0,32'h80017FFF,3,
        4'b0000,32'h0,32'hFFFF8001,0,0);
    add(1,0,2'b10,0,32'h5004,32'hDEADBEEF,32'h0,1,
        4'b1111,32'hDEADBEEF,32'hFFFF8001,0,0);
    add(0,1,2'b11,0,32'h6000,32'h0,32'hCAFEF00D,0,
        4'b0000,32'h0,32'hCAFEF00D,0,0);
    add(1,1,2'b00,0,32'h7001,32'h0000005A,32'h0,0,
        4'b0010,32'h5A5A5A5A,32'hCAFEF00D,0,0);
    add(1,0,2'b10,0,32'h8002,32'h0,32'h0,0,
        4'b0000,32'h0,32'hCAFEF00D,1,0);
    add(0,1,2'b00,0,32'h9001,32'h0,32'h00007F00,0,
        4'b0000,32'h0,32'h0000007F,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      run_txn(v.wr, v.rd, v.sz, v.un, v.a, v.sd, v.rdv, v.dly, r);
      compare($sformatf("vec%0d", i), r, v.wr, v.a, v.dly,
              v.mis, v.berr, v.be, v.wd, v.ld);
    end

    // Reset while the bus request is outstanding.
    @(negedge clk_in);
    req_valid_in = 1; mem_rd_req_in = 1; mem_wr_req_in = 0;
    load_size_in = 2'b10; addr_in = 32'hA000;
    @(negedge clk_in);
    req_valid_in = 0;
    repeat (2) @(negedge clk_in);
    chk("midrst.req_before", 32'(dmem_req_o), 1);
    rst_in = 0;
    #1;
    chk("midrst.req", 32'(dmem_req_o), 0);
    chk("midrst.stall", 32'(stall_o), 0);
    chk("midrst.load", load_data_o, 0);
    chk("midrst.others", 32'(|{dmem_we_o, dmem_addr_o, dmem_wdata_o,
        dmem_be_o, done_o, misaligned_o, bus_err_o}), 0);
    @(negedge clk_in);
    rst_in = 1;
    run_txn(0, 1, 2'b10, 0, 32'hB000, 32'h0, 32'h0BADF00D, 0, r);
    compare("postrst", r, 0, 32'hB000, 0, 0, 0, 4'b0000, 32'h0,
            32'h0BADF00D);

    ld_m = 32'h0BADF00D;
    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic        rd;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rdv;
      int          dly;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'b00;
      end
      sd = $urandom;
      rdv = $urandom;
      dly = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 4);
      model(wr, sz, un, a, sd, rdv, ld_m, dly >= 16,
            mbe, mwd, mld, mmis);
      run_txn(wr, rd, sz, un, a, sd, rdv, dly, r);
      compare($sformatf("rnd%0d", i), r, wr, a, dly, mmis,
              !mmis && dly >= 16, mbe, mwd, mld);
      ld_m = mld;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
